// File: rtl/w_window_fsm.sv
// Windowed ones-count qualifier: after a start strobe, counts w=1 samples over
// back-to-back windows of WINDOW enabled cycles and pulses z when the count qualifies.
module w_window_fsm #(
    parameter int WINDOW = 3,
    parameter int TARGET = 2,
    parameter int MODE   = 0,
    localparam int CW    = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          w,
    input  logic          en,
    input  logic          abort,
    output logic          z,
    output logic          win_done,
    output logic [CW-1:0] last_ones,
    output logic          busy
);

    localparam int PW = $clog2(WINDOW);
    localparam logic [PW-1:0] POS_LAST = PW'(WINDOW - 1);
    localparam logic [CW-1:0] TGT      = CW'(TARGET);

    // Handshake-free block: s/w/en/abort are level inputs sampled on every
    // rising edge; z and win_done are single-cycle registered pulses.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pos, pos_nx;
    logic [CW-1:0] ones, ones_nx;
    logic [CW-1:0] last_nx;
    logic [CW-1:0] final_cnt;
    logic          z_nx;
    logic          done_nx;

    function automatic logic qualify(input logic [CW-1:0] cnt);
        case (MODE)
            1:       return (cnt >= TGT);
            2:       return (cnt <= TGT);
            default: return (cnt == TGT);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pos       <= '0;
            ones      <= '0;
            z         <= 1'b0;
            win_done  <= 1'b0;
            last_ones <= '0;
        end else begin
            state     <= state_nx;
            pos       <= pos_nx;
            ones      <= ones_nx;
            z         <= z_nx;
            win_done  <= done_nx;
            last_ones <= last_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pos_nx    = pos;
        ones_nx   = ones;
        last_nx   = last_ones;
        z_nx      = 1'b0;
        done_nx   = 1'b0;
        // ones never exceeds WINDOW-1 before the final sample, so this fits in CW bits
        final_cnt = ones + CW'(w);

        case (state)
            IDLE: begin
                if (s) begin
                    state_nx = RUN;
                    pos_nx   = '0;
                    ones_nx  = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                    pos_nx   = '0;
                    ones_nx  = '0;
                end else if (en) begin
                    if (pos == POS_LAST) begin
                        last_nx = final_cnt;
                        done_nx = 1'b1;
                        z_nx    = qualify(final_cnt);
                        pos_nx  = '0;
                        ones_nx = '0;
                    end else begin
                        pos_nx  = pos + 1'b1;
                        ones_nx = final_cnt;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                pos_nx   = '0;
                ones_nx  = '0;
            end
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_w_window_fsm.sv
// Bench for w_window_fsm: three parameterisations share one stimulus stream;
// each vector names the instance whose outputs it predicts.
module tb_w_window_fsm;

    logic clk;
    logic reset;
    logic s;
    logic w;
    logic en;
    logic abort;

    logic       z0, d0, b0;
    logic [1:0] l0;
    logic       z1, d1, b1;
    logic [2:0] l1;
    logic       z2, d2, b2;
    logic [1:0] l2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       s;
        logic       w;
        logic       en;
        logic       ab;
        logic       ez;
        logic       ed;
        logic [2:0] el;
        logic       eb;
        logic [1:0] dut;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    // defaults: two-of-three
    w_window_fsm u_def (
        .clk(clk), .reset(reset), .s(s), .w(w), .en(en), .abort(abort),
        .z(z0), .win_done(d0), .last_ones(l0), .busy(b0)
    );

    w_window_fsm #(.WINDOW(5), .TARGET(3), .MODE(1)) u_ge (
        .clk(clk), .reset(reset), .s(s), .w(w), .en(en), .abort(abort),
        .z(z1), .win_done(d1), .last_ones(l1), .busy(b1)
    );

    w_window_fsm #(.WINDOW(3), .TARGET(0), .MODE(2)) u_le (
        .clk(clk), .reset(reset), .s(s), .w(w), .en(en), .abort(abort),
        .z(z2), .win_done(d2), .last_ones(l2), .busy(b2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic si, input logic wi, input logic ei,
                       input logic ai, input logic ez, input logic ed, input int el,
                       input logic eb, input int d);
        vec_t v;
        v.rst = r; v.s = si; v.w = wi; v.en = ei; v.ab = ai;
        v.ez = ez; v.ed = ed; v.el = 3'(el); v.eb = eb; v.dut = 2'(d);
        vecs.push_back(v);
    endtask

    task automatic check_one(input string name, input int idx, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, req);
        end
    endtask

    // driver: inputs change at negedge, expectation queued, outputs checked #1 after posedge
    task automatic step(input vec_t v, input int idx);
        logic [7:0] e;
        logic       az, ad, ab;
        logic [2:0] al;
        @(negedge clk);
        reset = v.rst; s = v.s; w = v.w; en = v.en; abort = v.ab;
        exp_q.push_back({v.dut, v.ez, v.ed, v.el, v.eb});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        case (e[7:6])
            2'd1:    begin az = z1; ad = d1; al = l1;         ab = b1; end
            2'd2:    begin az = z2; ad = d2; al = {1'b0, l2}; ab = b2; end
            default: begin az = z0; ad = d0; al = {1'b0, l0}; ab = b0; end
        endcase
        check_one("z",         idx, int'(az), int'(e[5]));
        check_one("win_done",  idx, int'(ad), int'(e[4]));
        check_one("last_ones", idx, int'(al), int'(e[3:1]));
        check_one("busy",      idx, int'(ab), int'(e[0]));
    endtask

    initial begin
        vec_t hv;
        reset = 1'b1; s = 1'b0; w = 1'b0; en = 1'b0; abort = 1'b0;

        // defaults: basic windows, s ignored in RUN, continuous run, reset mid-window
        add(1,0,0,0,0, 0,0,0,0, 0);
        add(0,1,0,0,0, 0,0,0,1, 0);
        add(0,0,1,1,0, 0,0,0,1, 0);
        add(0,0,1,1,0, 0,0,0,1, 0);
        add(0,0,0,1,0, 1,1,2,1, 0);
        add(0,0,1,1,0, 0,0,2,1, 0);
        add(0,1,1,1,0, 0,0,2,1, 0);
        add(0,0,1,1,0, 0,1,3,1, 0);
        add(0,0,0,1,0, 0,0,3,1, 0);
        add(0,0,1,1,0, 0,0,3,1, 0);
        add(0,0,1,1,0, 1,1,2,1, 0);
        add(0,0,1,1,0, 0,0,2,1, 0);
        add(0,0,0,1,0, 0,0,2,1, 0);
        add(0,0,1,1,0, 1,1,2,1, 0);
        add(0,0,0,1,0, 0,0,2,1, 0);
        add(0,0,0,1,0, 0,0,2,1, 0);
        add(0,0,0,1,0, 0,1,0,1, 0);
        add(0,0,1,1,0, 0,0,0,1, 0);
        add(0,0,1,1,0, 0,0,0,1, 0);
        add(1,0,1,1,0, 0,0,0,0, 0);

        // defaults: abort on the final sample of a qualifying window, then restart
        add(1,0,0,0,0, 0,0,0,0, 0);
        add(0,1,0,0,0, 0,0,0,1, 0);
        add(0,0,1,1,0, 0,0,0,1, 0);
        add(0,0,1,1,0, 0,0,0,1, 0);
        add(0,0,1,1,0, 0,1,3,1, 0);
        add(0,0,1,1,0, 0,0,3,1, 0);
        add(0,0,1,1,0, 0,0,3,1, 0);
        add(0,0,0,1,1, 0,0,3,0, 0);
        add(0,0,1,1,0, 0,0,3,0, 0);
        add(0,1,0,0,0, 0,0,3,1, 0);
        add(0,0,1,1,0, 0,0,3,1, 0);
        add(0,0,0,1,0, 0,0,3,1, 0);
        add(0,0,1,1,0, 1,1,2,1, 0);

        // WINDOW=5 TARGET=3 MODE=ge: two stall cycles mid-window
        add(1,0,0,0,0, 0,0,0,0, 1);
        add(0,1,0,0,0, 0,0,0,1, 1);
        add(0,0,1,1,0, 0,0,0,1, 1);
        add(0,0,0,1,0, 0,0,0,1, 1);
        add(0,0,1,0,0, 0,0,0,1, 1);
        add(0,0,1,0,0, 0,0,0,1, 1);
        add(0,0,1,1,0, 0,0,0,1, 1);
        add(0,0,0,1,0, 0,0,0,1, 1);
        add(0,0,1,1,0, 1,1,3,1, 1);
        add(0,0,1,0,0, 0,0,3,1, 1);
        add(0,0,1,1,0, 0,0,3,1, 1);
        add(0,0,1,1,0, 0,0,3,1, 1);
        add(0,0,0,1,0, 0,0,3,1, 1);
        add(0,0,0,1,0, 0,0,3,1, 1);
        add(0,0,0,1,0, 0,1,2,1, 1);

        // WINDOW=3 TARGET=0 MODE=le
        add(1,0,0,0,0, 0,0,0,0, 2);
        add(0,1,0,0,0, 0,0,0,1, 2);
        add(0,0,0,1,0, 0,0,0,1, 2);
        add(0,0,0,1,0, 0,0,0,1, 2);
        add(0,0,0,1,0, 1,1,0,1, 2);
        add(0,0,0,1,0, 0,0,0,1, 2);
        add(0,0,1,1,0, 0,0,0,1, 2);
        add(0,0,0,1,0, 0,1,1,1, 2);

        foreach (vecs[i]) step(vecs[i], i);

        // after reset with s held low, random w/en/abort must never start the block
        hv.rst = 1'b1; hv.s = 1'b0; hv.w = 1'b1; hv.en = 1'b1; hv.ab = 1'b0;
        hv.ez = 1'b0; hv.ed = 1'b0; hv.el = 3'd0; hv.eb = 1'b0; hv.dut = 2'd0;
        step(hv, 1000);
        hv.rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            hv.w   = 1'($urandom_range(0, 1));
            hv.en  = 1'($urandom_range(0, 1));
            hv.ab  = 1'($urandom_range(0, 1));
            hv.dut = 2'($urandom_range(0, 2));
            step(hv, 1001 + k);
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL exp_q_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
